bit_pipe_chain: RTL and testbench

Parametrised elastic pipeline register chain for the bit-level pipelining datapath: WIDTH-bit data moves through DEPTH register stages with a valid/ready handshake at both ends. It generalises the single set/reset D flip-flop into a multi-stage, multi-bit bank with bubble collapsing, backpressure, flush and an occupancy count. It sits between pipelined arithmetic stages wherever a fixed-latency, stallable delay line is needed.

---
 rtl/bit_pipe_pkg.sv | 9 +
 rtl/bit_pipe_chain_if.sv | 15 +
 rtl/bit_pipe_stage.sv | 40 ++++
 rtl/bit_pipe_chain.sv | 101 ++++++++++
 tb/tb_bit_pipe_chain.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bit_pipe_pkg.sv
// Shared helpers for the bit-level pipeline register chain.
package bit_pipe_pkg;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bit_pipe_chain_if.sv
// Valid/ready stream bundle carrying WIDTH-bit words.
interface bit_pipe_chain_if #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  // Producer side drives valid/data and observes ready.
  modport master (output valid, output data, input ready);
  // Consumer side observes valid/data and drives ready.
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/bit_pipe_stage.sv
// One stage of the elastic chain: valid bit plus data word with
// reset > flush > set > advance priority.
module bit_pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             flush,
  input  logic             adv,
  input  logic             up_v,
  input  logic [WIDTH-1:0] up_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_reg;
  logic [WIDTH-1:0] d_reg;

  // Stage register: load from upstream on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_reg <= 1'b0;
      d_reg <= '0;
    end else if (flush) begin
      v_reg <= 1'b0;
    end else if (set) begin
      v_reg <= 1'b1;
      d_reg <= SET_VAL;
    end else if (adv) begin
      v_reg <= up_v;
      d_reg <= up_d;
    end
  end

  assign v = v_reg;
  assign d = d_reg;

endmodule

// File: rtl/bit_pipe_chain.sv
// Elastic DEPTH-stage pipeline register chain with bubble collapsing,
// backpressure, set/flush and a registered occupancy count.
// Note: the out_ready -> in_ready path ripples through DEPTH OR gates.
module bit_pipe_chain
  import bit_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set,
  input  logic                      flush,
  bit_pipe_chain_if.slave           up,
  bit_pipe_chain_if.master          dn,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          in_hs;
  logic          out_hs;

  // The last stage advances when drained or empty; earlier stages also
  // advance whenever they are empty, so bubbles collapse under a stall.
  assign adv[DEPTH-1] = dn.ready | ~v[DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_v[gi] = up.valid;
        assign src_d[gi] = up.data;
      end else begin : g_body
        assign src_v[gi] = v[gi-1];
        assign src_d[gi] = d[gi-1];
      end

      if (gi < DEPTH - 1) begin : g_adv
        assign adv[gi] = adv[gi+1] | ~v[gi];
      end

      bit_pipe_stage #(
        .WIDTH   (WIDTH),
        .SET_VAL (SET_VAL)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .set   (set),
        .flush (flush),
        .adv   (adv[gi]),
        .up_v  (src_v[gi]),
        .up_d  (src_d[gi]),
        .v     (v[gi]),
        .d     (d[gi])
      );
    end
  endgenerate

  assign up.ready = rst & adv[0];
  assign dn.valid = v[DEPTH-1];
  assign dn.data  = d[DEPTH-1];

  assign in_hs  = up.valid & up.ready;
  assign out_hs = dn.valid & dn.ready;

  // Next occupancy: preset/flush override, else +1 push, -1 pop.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (set) begin
      count_next = CW'(DEPTH);
    end else if (in_hs && !out_hs) begin
      count_next = count_reg + CW'(1);
    end else if (out_hs && !in_hs) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_bit_pipe_chain.sv
// Self-checking bench for bit_pipe_chain (WIDTH=8, DEPTH=4) against a
// queue-based model of the words in flight.
module tb_bit_pipe_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       set;
  logic       flush;
  logic [2:0] count;

  bit_pipe_chain_if #(.WIDTH(WIDTH)) up_if ();
  bit_pipe_chain_if #(.WIDTH(WIDTH)) dn_if ();

  bit_pipe_chain #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .SET_VAL (8'hFF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .set   (set),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if),
    .count (count)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  item_t q[$];        // oldest word first
  bit    started = 0; // registers defined once a reset edge has passed
  bit    data_zero = 0;
  int    txn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s txn=%0d observed=0x%0h expected=0x%0h", tag, txn, obs, exp);
    end
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance the model.
  task automatic cyc(input logic rs, input logic st, input logic fl,
                     input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    logic  exp_ready;
    logic  exp_ov;
    item_t nq[$];
    item_t it;
    @(negedge clk);
    rst = rs; set = st; flush = fl;
    up_if.valid = iv; up_if.data = id; dn_if.ready = ordy;
    #1;
    exp_ready = rs && (ordy || q.size() < DEPTH);
    exp_ov    = (q.size() > 0) && (q[0].pos == DEPTH - 1);
    txn++;
    if (started) begin
      chk("in_ready", 32'(up_if.ready), 32'(exp_ready));
      chk("out_valid", 32'(dn_if.valid), 32'(exp_ov));
      chk("count", 32'(count), 32'(q.size()));
      if (exp_ov) chk("out_data", 32'(dn_if.data), 32'(q[0].d));
      else if (data_zero) chk("out_data_rst", 32'(dn_if.data), 32'h0);
    end
    $display("txn %0d rst=%0b set=%0b flush=%0b in=%0b/%02h ordy=%0b -> rdy=%0b ov=%0b od=%02h cnt=%0d",
             txn, rs, st, fl, iv, id, ordy, up_if.ready, dn_if.valid, dn_if.data, count);
    if (!rs) begin
      q.delete();
      data_zero = 1;
    end else begin
      data_zero = 0;
      if (fl) begin
        q.delete();
      end else if (st) begin
        q.delete();
        for (int p = DEPTH - 1; p >= 0; p--) begin
          it.d = 8'hFF; it.pos = p; q.push_back(it);
        end
      end else begin
        // A word moves forward when the output is drained or any slot
        // ahead of it is free; the word at the end leaves on a pop.
        for (int k = 0; k < q.size(); k++) begin
          it = q[k];
          if (it.pos == DEPTH - 1) begin
            if (!ordy) nq.push_back(it);
          end else begin
            if (ordy || (k < DEPTH - 1 - it.pos)) it.pos++;
            nq.push_back(it);
          end
        end
        if (iv && exp_ready) begin
          it.d = id; it.pos = 0; nq.push_back(it);
        end
        q = nq;
      end
    end
    @(posedge clk);
    if (!rs) started = 1;
  endtask

  initial begin
    rst = 1'b0; set = 1'b0; flush = 1'b0;
    up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;

    // Reset.
    cyc(0, 0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'h11, 1);

    // Streaming 0x01..0x08 at full rate.
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 1, 8'(i), 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'h00, 1);

    // Fill with backpressure, refused extra word, then drain.
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 1, 8'(i), 0);
    cyc(1, 0, 0, 1, 8'h99, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'h00, 1);

    // Bubble collapse under stall.
    cyc(1, 0, 0, 1, 8'hA0, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 1, 8'hA1, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8'h00, 1);

    // Set with chain half full, then drain the preset words.
    cyc(1, 0, 0, 1, 8'hB0, 0);
    cyc(1, 0, 0, 1, 8'hB1, 0);
    cyc(1, 1, 0, 1, 8'hB2, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'h00, 1);

    // Flush and set together while full, with a word offered.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'(8'hC0 + i), 0);
    cyc(1, 1, 1, 1, 8'h77, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'h00, 1);

    // Reset mid-stream, then one word.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 8'(8'hD0 + i), 1);
    cyc(0, 0, 0, 1, 8'hEE, 1);
    cyc(1, 0, 0, 1, 8'h55, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'h00, 1);

    // Randomized traffic with occasional control events.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(63) != 0), ($urandom_range(31) == 0), ($urandom_range(31) == 0),
          1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
